// File: rtl/soc_bus_pkg.sv
// Shared definitions for the data-bus decoder: slave address map, slave id type,
// and the address decode helper used by the decoder.
package soc_bus_pkg;

  localparam int SOC_NUM_SLAVES = 4;
  localparam int SLAVE_ID_W     = $clog2(SOC_NUM_SLAVES + 1);

  typedef logic [SLAVE_ID_W-1:0] slave_id_t;

  // One id past the last slave marks requests that the decoder answers itself.
  localparam slave_id_t ERR_ID = slave_id_t'(SOC_NUM_SLAVES);

  localparam int SLV_RAM   = 0;
  localparam int SLV_GPIO  = 1;
  localparam int SLV_SPI   = 2;
  localparam int SLV_TIMER = 3;

  // Index 0 is the rightmost element: RAM, GPIO, SPI, TIMER.
  localparam logic [SOC_NUM_SLAVES-1:0][31:0] SLV_BASE = {
    32'h0100_2000,
    32'h0100_1000,
    32'h0100_0000,
    32'h0000_0000
  };

  localparam logic [SOC_NUM_SLAVES-1:0][31:0] SLV_MASK = {
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFFFF_0000
  };

  // Lowest matching index wins, so the scan runs from the top down.
  function automatic slave_id_t decode_addr(input logic [31:0] addr);
    slave_id_t sel;
    sel = ERR_ID;
    for (int i = SOC_NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i]) == SLV_BASE[i]) begin
        sel = slave_id_t'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_bus_decoder_if.sv
// Ibex data-port bus on the master side plus the fanned-out slave side, bundled
// so the decoder and its environment share one connection point.
//
// Handshake: a request is accepted on a cycle where m_req & m_gnt; the master
// holds m_addr/m_we/m_be/m_wdata stable while m_req & !m_gnt. Each accepted
// request gets exactly one m_rvalid pulse, in acceptance order. Slaves follow
// the same rule per port with s_req[i]/s_gnt[i] and s_rvalid[i].
interface data_bus_decoder_if #(
  parameter int NUM_SLAVES = 4
);

  logic                     m_req;
  logic                     m_gnt;
  logic                     m_we;
  logic [3:0]               m_be;
  logic [31:0]              m_addr;
  logic [31:0]              m_wdata;
  logic                     m_rvalid;
  logic [31:0]              m_rdata;
  logic                     m_err;

  logic [NUM_SLAVES-1:0]    s_req;
  logic [NUM_SLAVES-1:0]    s_gnt;
  logic                     s_we;
  logic [3:0]               s_be;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [NUM_SLAVES-1:0]    s_rvalid;
  logic [NUM_SLAVES*32-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]    s_err;

  // The decoder's view: it is the slave of the Ibex data port.
  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata, m_err,
    output s_req, s_we, s_be, s_addr, s_wdata,
    input  s_gnt, s_rvalid, s_rdata, s_err
  );

  // The environment's view: Ibex master plus the peripheral slaves.
  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata, m_err,
    input  s_req, s_we, s_be, s_addr, s_wdata,
    output s_gnt, s_rvalid, s_rdata, s_err
  );

endinterface

// File: rtl/data_bus_decoder_rsp_id_fifo.sv
// In-order FIFO of slave ids for granted-but-unanswered requests; the head says
// which slave's response goes back to the master next.
module rsp_id_fifo
  import soc_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  slave_id_t push_id,
  input  logic      pop,
  output slave_id_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  slave_id_t        mem [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointers wrap naturally; count alone decides empty/full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

endmodule

// File: rtl/data_bus_decoder.sv
// Address decoder between the Ibex data port and its slaves: routes req/gnt to
// one slave, answers unmapped addresses with an error, and steers responses back in order.
module data_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int NUM_SLAVES      = SOC_NUM_SLAVES,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           rst,
  data_bus_decoder_if.slave bus
);

  slave_id_t             sel;
  slave_id_t             head;
  logic                  empty;
  logic                  full;
  logic                  req_ok;
  logic                  gnt;
  logic                  push;
  logic                  pop;
  logic [NUM_SLAVES-1:0] s_req;
  logic [NUM_SLAVES-1:0] head_mask;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic                  err;

  assign sel = decode_addr(bus.m_addr);

  // Full comes from the registered count only, so a same-cycle pop never frees a slot.
  assign req_ok = bus.m_req & ~full & ~rst;

  always_comb begin
    s_req = '0;
    gnt   = 1'b0;
    if (req_ok) begin
      if (sel == ERR_ID) begin
        gnt = 1'b1;
      end
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel == slave_id_t'(i)) begin
          s_req[i] = 1'b1;
          gnt      = bus.s_gnt[i];
        end
      end
    end
  end

  always_comb begin
    rvalid    = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    head_mask = '0;
    if (!rst && !empty) begin
      if (head == ERR_ID) begin
        rvalid = 1'b1;
        err    = 1'b1;
      end
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (head == slave_id_t'(i)) begin
          head_mask[i] = 1'b1;
          rvalid       = bus.s_rvalid[i];
          rdata        = bus.s_rdata[32*i +: 32];
          err          = bus.s_err[i];
        end
      end
    end
  end

  assign push = bus.m_req & gnt;
  assign pop  = rvalid;

  rsp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head    (head),
    .empty   (empty),
    .full    (full)
  );

  assign bus.m_gnt    = gnt;
  assign bus.m_rvalid = rvalid;
  assign bus.m_rdata  = rdata;
  assign bus.m_err    = err;
  assign bus.s_req    = s_req;
  assign bus.s_we     = bus.m_we;
  assign bus.s_be     = bus.m_be;
  assign bus.s_addr   = bus.m_addr;
  assign bus.s_wdata  = bus.m_wdata;

  // A slave answering out of turn (or with nothing outstanding) is dropped, never forwarded.
  spurious_rvalid_a: assert property (
    @(posedge clk) disable iff (rst) ((bus.s_rvalid & ~head_mask) == '0)
  ) else $warning("spurious s_rvalid %b ignored", bus.s_rvalid);

endmodule

// File: tb/tb_data_bus_decoder.sv
// Bench for data_bus_decoder: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against an address-map/queue model.
module tb_data_bus_decoder;

  localparam int NS  = 4;
  localparam int MO  = 2;
  localparam int ERR = NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_decoder_if #(.NUM_SLAVES(NS)) bus ();

  data_bus_decoder #(
    .NUM_SLAVES      (NS),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [2:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       last_gnt = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Address map as plain ranges.
  function automatic int tb_decode(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h0100_0000 && a < 32'h0100_1000) return 1;
    if (a >= 32'h0100_1000 && a < 32'h0100_2000) return 2;
    if (a >= 32'h0100_2000 && a < 32'h0100_3000) return 3;
    return ERR;
  endfunction

  // Model: a queue of who owes the master a response.
  always @(negedge clk) begin : compare
    int          sel;
    int          head;
    bit          full;
    logic        exp_gnt;
    logic [3:0]  exp_sreq;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_err;
    sel        = tb_decode(bus.m_addr);
    full       = (exp_q.size() >= MO);
    exp_gnt    = 1'b0;
    exp_sreq   = 4'b0;
    exp_rvalid = 1'b0;
    exp_rdata  = 32'h0;
    exp_err    = 1'b0;
    head       = -1;
    if (!rst && bus.m_req && !full) begin
      if (sel == ERR) begin
        exp_gnt = 1'b1;
      end else begin
        exp_gnt       = bus.s_gnt[sel];
        exp_sreq[sel] = 1'b1;
      end
    end
    if (!rst && exp_q.size() > 0) begin
      head = int'(exp_q[0]);
      if (head == ERR) begin
        exp_rvalid = 1'b1;
        exp_err    = 1'b1;
      end else begin
        exp_rvalid = bus.s_rvalid[head];
        exp_rdata  = bus.s_rdata[32*head +: 32];
        exp_err    = bus.s_err[head];
      end
    end
    check("m_gnt", 128'(bus.m_gnt), 128'(exp_gnt));
    check("s_req", 128'(bus.s_req), 128'(exp_sreq));
    check("m_rvalid", 128'(bus.m_rvalid), 128'(exp_rvalid));
    if (exp_rvalid || head < 0) begin
      check("m_rdata", 128'(bus.m_rdata), 128'(exp_rdata));
      check("m_err", 128'(bus.m_err), 128'(exp_err));
    end
    check("broadcast", 128'({bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata}),
          128'({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata}));
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_rvalid) void'(exp_q.pop_front());
      if (exp_gnt) exp_q.push_back(3'(sel));
    end
    last_gnt = exp_gnt;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.m_req    = 1'b0;
    bus.s_gnt    = '0;
    bus.s_rvalid = '0;
    bus.s_err    = '0;
  endtask

  task automatic req(input logic [31:0] addr, input logic we);
    bus.m_req   = 1'b1;
    bus.m_addr  = addr;
    bus.m_we    = we;
    bus.m_be    = 4'hF;
    bus.m_wdata = $urandom;
  endtask

  initial begin
    bus.m_addr  = '0;
    bus.m_we    = 1'b0;
    bus.m_be    = '0;
    bus.m_wdata = '0;
    bus.s_rdata = '0;
    idle();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    smp();
    check("reset_rvalid", 128'(bus.m_rvalid), 128'(0));
    check("reset_gnt", 128'(bus.m_gnt), 128'(0));
    check("reset_sreq", 128'(bus.s_req), 128'(0));

    // GPIO read, response two cycles after the grant.
    cyc(); req(32'h0100_0004, 1'b0); bus.s_gnt = 4'b0010;
    smp(); check("gpio_gnt", 128'(bus.m_gnt), 128'(1));
    check("gpio_sreq", 128'(bus.s_req), 128'(4'b0010));
    cyc(); idle();
    smp(); check("gpio_wait", 128'(bus.m_rvalid), 128'(0));
    cyc(); bus.s_rvalid = 4'b0010; bus.s_rdata[63:32] = 32'h1234_5678;
    smp(); check("gpio_rvalid", 128'(bus.m_rvalid), 128'(1));
    check("gpio_rdata", 128'(bus.m_rdata), 128'(32'h1234_5678));
    check("gpio_err", 128'(bus.m_err), 128'(0));
    cyc(); idle();
    smp(); check("gpio_done", 128'(bus.m_rvalid), 128'(0));

    // Unmapped address: local grant, error one cycle later.
    cyc(); req(32'h0800_0000, 1'b1);
    smp(); check("unmap_gnt", 128'(bus.m_gnt), 128'(1));
    check("unmap_sreq", 128'(bus.s_req), 128'(0));
    cyc(); idle();
    smp(); check("unmap_rvalid", 128'(bus.m_rvalid), 128'(1));
    check("unmap_err", 128'(bus.m_err), 128'(1));
    check("unmap_rdata", 128'(bus.m_rdata), 128'(0));
    cyc();
    smp(); check("unmap_done", 128'(bus.m_rvalid), 128'(0));

    // RAM then TIMER; TIMER answers early and is ignored.
    cyc(); req(32'h0000_0100, 1'b0); bus.s_gnt = 4'b0001;
    smp(); check("ram_gnt", 128'(bus.m_gnt), 128'(1));
    cyc(); req(32'h0100_2000, 1'b0); bus.s_gnt = 4'b1000;
    smp(); check("timer_gnt", 128'(bus.m_gnt), 128'(1));
    check("timer_sreq", 128'(bus.s_req), 128'(4'b1000));
    cyc(); idle(); bus.s_rvalid = 4'b1000; bus.s_rdata[127:96] = 32'h0000_AAAA;
    smp(); check("early_timer", 128'(bus.m_rvalid), 128'(0));
    cyc(); bus.s_rvalid = 4'b0001; bus.s_rdata[31:0] = 32'h1111_0000;
    smp(); check("ram_rsp", 128'(bus.m_rvalid), 128'(1));
    check("ram_rdata", 128'(bus.m_rdata), 128'(32'h1111_0000));
    cyc(); bus.s_rvalid = 4'b1000; bus.s_rdata[127:96] = 32'h0000_BBBB;
    smp(); check("timer_rsp", 128'(bus.m_rvalid), 128'(1));
    check("timer_rdata", 128'(bus.m_rdata), 128'(32'h0000_BBBB));
    cyc(); idle();
    smp(); check("ooo_done", 128'(bus.m_rvalid), 128'(0));

    // Two outstanding RAM reads block a third until one answers.
    cyc(); req(32'h0000_0010, 1'b0); bus.s_gnt = 4'b0001;
    cyc(); req(32'h0000_0020, 1'b0);
    cyc(); req(32'h0000_0200, 1'b0);
    smp(); check("full_gnt", 128'(bus.m_gnt), 128'(0));
    check("full_sreq", 128'(bus.s_req), 128'(0));
    cyc();
    smp(); check("full_gnt2", 128'(bus.m_gnt), 128'(0));
    cyc(); bus.s_rvalid = 4'b0001;
    smp(); check("full_pop_rvalid", 128'(bus.m_rvalid), 128'(1));
    check("full_pop_gnt", 128'(bus.m_gnt), 128'(0));
    cyc(); bus.s_rvalid = 4'b0000;
    smp(); check("unfull_gnt", 128'(bus.m_gnt), 128'(1));
    check("unfull_sreq", 128'(bus.s_req), 128'(4'b0001));
    cyc(); idle(); bus.s_rvalid = 4'b0001;
    smp(); check("drain1", 128'(bus.m_rvalid), 128'(1));
    cyc();
    smp(); check("drain2", 128'(bus.m_rvalid), 128'(1));
    cyc(); idle();
    smp(); check("drained", 128'(bus.m_rvalid), 128'(0));

    // GPIO stalls the grant for three cycles.
    cyc(); req(32'h0100_0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      smp(); check("stall_gnt", 128'(bus.m_gnt), 128'(0));
      check("stall_sreq", 128'(bus.s_req), 128'(4'b0010));
      cyc();
    end
    bus.s_gnt = 4'b0010;
    smp(); check("stall_granted", 128'(bus.m_gnt), 128'(1));
    cyc(); idle(); bus.s_rvalid = 4'b0010;
    smp(); check("stall_rsp", 128'(bus.m_rvalid), 128'(1));
    cyc();
    smp(); check("stall_one_push", 128'(bus.m_rvalid), 128'(0));
    cyc(); idle();

    // Reset with a request outstanding.
    cyc(); req(32'h0000_0040, 1'b0); bus.s_gnt = 4'b0001;
    cyc(); idle(); rst = 1'b1;
    smp(); check("rst_rvalid", 128'(bus.m_rvalid), 128'(0));
    cyc(); rst = 1'b0;
    cyc(); bus.s_rvalid = 4'b0001;
    smp(); check("post_rst_drop", 128'(bus.m_rvalid), 128'(0));
    cyc(); idle(); req(32'h0100_3000, 1'b0);
    smp(); check("post_rst_gnt", 128'(bus.m_gnt), 128'(1));
    cyc(); idle();
    smp(); check("post_rst_err", 128'(bus.m_err), 128'(1));
    check("post_rst_rvalid", 128'(bus.m_rvalid), 128'(1));
    cyc();

    // Randomized traffic; slaves answer only when they are the model's head.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!bus.m_req || last_gnt) begin
        if ($urandom_range(0, 99) < 65) begin
          case ($urandom_range(0, 5))
            0: req(32'h0000_0000 | ($urandom & 32'h0000_FFFC), $urandom_range(0, 1) == 1);
            1: req(32'h0100_0000 | ($urandom & 32'h0000_0FFC), $urandom_range(0, 1) == 1);
            2: req(32'h0100_1000 | ($urandom & 32'h0000_0FFC), $urandom_range(0, 1) == 1);
            3: req(32'h0100_2000 | ($urandom & 32'h0000_0FFC), $urandom_range(0, 1) == 1);
            4: req(32'h0100_3000 | ($urandom & 32'h0000_0FFC), $urandom_range(0, 1) == 1);
            default: req($urandom | 32'h1000_0000, $urandom_range(0, 1) == 1);
          endcase
          bus.m_be = 4'($urandom_range(0, 15));
        end else begin
          bus.m_req = 1'b0;
        end
      end
      bus.s_gnt    = 4'($urandom_range(0, 15));
      bus.s_err    = 4'($urandom_range(0, 15));
      bus.s_rdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.s_rvalid = '0;
      if (exp_q.size() > 0 && int'(exp_q[0]) != ERR && $urandom_range(0, 1) == 1) begin
        bus.s_rvalid[exp_q[0]] = 1'b1;
      end
    end
    cyc(); idle();
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
